// File: rtl/prompt_sequencer.sv
// Prompt sequencer: appends codes, plays them back, then checks user echo.
// Define PROMPT_SEQUENCER_INPUT_TIMEOUT_EN to fail LISTEN after TIMEOUT_TICKS idle cycles.
module prompt_sequencer #(
  parameter int DEPTH         = 16,
  parameter int ON_TICKS      = 50000000,
  parameter int GAP_TICKS     = 12500000,
  parameter int TIMEOUT_TICKS = 250000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               new_code,
  input  logic                     replay,
  input  logic                     restart,
  input  logic                     user_valid,
  input  logic [1:0]               user_code,
  output logic [2:0]               prompt,
  output logic                     busy,
  output logic                     round_pass,
  output logic                     round_fail,
  output logic [$clog2(DEPTH):0]   length,
  output logic                     full
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int T1   = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TMAX = (TIMEOUT_TICKS > T1) ? TIMEOUT_TICKS : T1;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);
`ifdef PROMPT_SEQUENCER_INPUT_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_SHOW,
    S_GAP,
    S_LISTEN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic [1:0]      code_q, code_d;
  logic [2:0]      prompt_q, prompt_d;
  logic            busy_q, busy_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            full_q, full_d;

  logic [1:0]      mem_q [DEPTH];
  logic            mem_we;
  logic            last;
  logic [1:0]      cur;

  assign last = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign cur  = mem_q[idx_q];

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      tick_q   <= '0;
      code_q   <= '0;
      prompt_q <= '0;
      busy_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      tick_q   <= tick_d;
      code_q   <= code_d;
      prompt_q <= prompt_d;
      busy_q   <= busy_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      full_q   <= full_d;
    end
  end

  // Sequence storage is intentionally not reset
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[len_q[AW-1:0]] <= code_q;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    code_d  = code_q;
    mem_we  = 1'b0;
    if (restart) begin
      state_d = S_IDLE;
      len_d   = '0;
      idx_d   = '0;
      tick_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            code_d  = new_code;
            idx_d   = '0;
            tick_d  = '0;
            state_d = full_q ? S_SHOW : S_APPEND;
          end else if (replay && (len_q != '0)) begin
            idx_d   = '0;
            tick_d  = '0;
            state_d = S_SHOW;
          end
        end
        S_APPEND: begin
          mem_we  = 1'b1;
          len_d   = len_q + LW'(1);
          idx_d   = '0;
          tick_d  = '0;
          state_d = S_SHOW;
        end
        S_SHOW: begin
          if (tick_q == ON_LAST) begin
            tick_d  = '0;
            state_d = S_GAP;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
        S_GAP: begin
          if (tick_q == GAP_LAST) begin
            tick_d = '0;
            if (last) begin
              idx_d   = '0;
              state_d = S_LISTEN;
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = S_SHOW;
            end
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
        S_LISTEN: begin
          if (user_valid) begin
            tick_d = '0;
            if (user_code != cur) begin
              state_d = S_FAIL;
            end else if (last) begin
              state_d = S_PASS;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end
`ifdef PROMPT_SEQUENCER_INPUT_TIMEOUT_EN
          else if (tick_q == TO_LAST) begin
            tick_d  = '0;
            state_d = S_FAIL;
          end else begin
            tick_d = tick_q + CW'(1);
          end
`endif
        end
        S_PASS, S_FAIL: begin
          idx_d   = '0;
          tick_d  = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Prompt lags the SHOW state by one cycle; restart blanks it at once
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    pass_d   = (state_d == S_PASS);
    fail_d   = (state_d == S_FAIL);
    full_d   = (len_d == LW'(DEPTH));
    prompt_d = 3'd0;
    if ((state_q == S_SHOW) && !restart) begin
      prompt_d = {1'b0, cur} + 3'd1;
    end
  end

  assign prompt     = prompt_q;
  assign busy       = busy_q;
  assign round_pass = pass_q;
  assign round_fail = fail_q;
  assign length     = len_q;
  assign full       = full_q;

endmodule

// File: tb/tb_prompt_sequencer.sv
// Directed bench for prompt_sequencer with short tick parameters.
module tb_prompt_sequencer;

  localparam int DEPTH = 4;
  localparam int ON    = 4;
  localparam int GAP   = 2;
  localparam int TO    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       replay = 1'b0;
  logic       restart = 1'b0;
  logic       user_valid = 1'b0;
  logic [1:0] new_code = '0;
  logic [1:0] user_code = '0;
  logic [2:0] prompt;
  logic       busy;
  logic       round_pass;
  logic       round_fail;
  logic [2:0] length;
  logic       full;

  int checks = 0;
  int errors = 0;

  logic [1:0] seq [DEPTH];
  int         seq_len = 0;

  prompt_sequencer #(
    .DEPTH(DEPTH),
    .ON_TICKS(ON),
    .GAP_TICKS(GAP),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .start(start),
    .new_code(new_code),
    .replay(replay),
    .restart(restart),
    .user_valid(user_valid),
    .user_code(user_code),
    .prompt(prompt),
    .busy(busy),
    .round_pass(round_pass),
    .round_fail(round_fail),
    .length(length),
    .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] c);
    start = 1'b1;
    new_code = c;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_prompt", prompt, 0);
  endtask

  task automatic play;
    for (int i = 0; i < seq_len; i++) begin
      repeat (ON) begin
        step();
        chk("show", prompt, int'(seq[i]) + 1);
      end
      repeat (GAP) begin
        step();
        chk("gap", prompt, 0);
      end
    end
    chk("listen_busy", busy, 1);
  endtask

  task automatic new_round(input logic [1:0] c);
    seq[seq_len] = c;
    seq_len++;
    pulse_start(c);
    step();
    chk("append_len", length, seq_len);
    chk("append_prompt", prompt, 0);
    play();
  endtask

  task automatic enter(input logic [1:0] c);
    user_valid = 1'b1;
    user_code = c;
    step();
    user_valid = 1'b0;
  endtask

  task automatic answer_ok;
    for (int i = 0; i < seq_len - 1; i++) begin
      enter(seq[i]);
      chk("mid_pass", round_pass, 0);
      chk("mid_fail", round_fail, 0);
    end
    enter(seq[seq_len-1]);
    chk("pass_pulse", round_pass, 1);
    chk("pass_nofail", round_fail, 0);
    step();
    chk("pass_end", round_pass, 0);
    chk("pass_idle", busy, 0);
    chk("pass_len", length, seq_len);
  endtask

  initial begin
    repeat (2) step();
    chk("rst_prompt", prompt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", length, 0);
    chk("rst_full", full, 0);
    chk("rst_pass", round_pass, 0);
    chk("rst_fail", round_fail, 0);
    rst_n = 1'b1;
    step();

    // single-code round
    new_round(2'd2);
    answer_ok();

    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("idle_restart_len", length, 0);
    chk("idle_restart_busy", busy, 0);
    seq_len = 0;

    replay = 1'b1;
    step();
    replay = 1'b0;
    chk("replay_empty", busy, 0);

    new_round(2'd0);
    answer_ok();
    new_round(2'd3);
    answer_ok();
    new_round(2'd1);
    enter(2'd0);
    chk("f_mid1", round_fail, 0);
    enter(2'd3);
    chk("f_mid2", round_fail, 0);
    enter(2'd2);
    chk("fail_pulse", round_fail, 1);
    chk("fail_nopass", round_pass, 0);
    step();
    chk("fail_end", round_fail, 0);
    chk("fail_idle", busy, 0);
    chk("fail_len", length, 3);

    replay = 1'b1;
    step();
    replay = 1'b0;
    chk("replay_busy", busy, 1);
    chk("replay_len", length, 3);
    play();
    answer_ok();

    new_round(2'd2);
    chk("full_flag", full, 1);
    answer_ok();

    pulse_start(2'd1);
    chk("full_len", length, 4);
    play();
    chk("full_len2", length, 4);

    repeat (TO - 1) step();
    chk("to_early", round_fail, 0);
    step();
`ifdef PROMPT_SEQUENCER_INPUT_TIMEOUT_EN
    chk("to_fail", round_fail, 1);
    step();
    chk("to_idle", busy, 0);
`else
    chk("to_nofail", round_fail, 0);
    chk("to_listen", busy, 1);
`endif

    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_len", length, 0);
    chk("rs_full", full, 0);
    seq_len = 0;

    // abort in the middle of SHOW
    pulse_start(2'd3);
    repeat (3) step();
    chk("abort_show", prompt, 4);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("abort_prompt", prompt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_len", length, 0);
    chk("abort_pass", round_pass, 0);
    chk("abort_fail", round_fail, 0);
    enter(2'd3);
    chk("ign_pass", round_pass, 0);
    chk("ign_fail", round_fail, 0);
    chk("ign_busy", busy, 0);

    // asynchronous reset mid-round
    pulse_start(2'd1);
    repeat (3) step();
    chk("pre_rst_prompt", prompt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_prompt", prompt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_len", length, 0);
    chk("arst_pass", round_pass, 0);
    chk("arst_fail", round_fail, 0);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_fail", round_fail, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prompt_sequencer.md
PROMPT_SEQUENCER -- requirements
Module: prompt_sequencer

Interface
REQ-001 Parameter DEPTH, 16, maximum sequence length; a power of two, 2..64.
REQ-002 Parameter ON_TICKS, 50000000, number of clock cycles each prompt is shown.
REQ-003 Parameter GAP_TICKS, 12500000, number of blank cycles after each prompt.
REQ-004 Parameter TIMEOUT_TICKS, 250000000, user-input timeout in cycles; used only with INPUT_TIMEOUT_EN.
REQ-005 Port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1, asynchronous, active-low reset.
REQ-007 Port start, input, 1, begin a round: append new_code, then play back.
REQ-008 Port new_code, input, 2, prompt code to append (0..3).
REQ-009 Port replay, input, 1, play back the existing sequence without appending.
REQ-010 Port restart, input, 1, clear the sequence (new game).
REQ-011 Port user_valid, input, 1, one-cycle pulse marking one user response.
REQ-012 Port user_code, input, 2, the user's response code, qualified by user_valid.
REQ-013 Port prompt, output, 3, 0 = blank, otherwise code+1 (1..4).
REQ-014 Port busy, output, 1, high in every state except IDLE.
REQ-015 Port round_pass, output, 1, one-cycle pulse when the full sequence is matched.
REQ-016 Port round_fail, output, 1, one-cycle pulse on a mismatch or timeout.
REQ-017 Port length, output, clog2(DEPTH)+1, current sequence length.
REQ-018 Port full, output, 1, high when length == DEPTH.

Function
REQ-019 The block SHALL be an FSM with states IDLE, APPEND, SHOW, GAP, LISTEN, PASS and FAIL; all outputs SHALL be registered.
REQ-020 In IDLE, input priority SHALL be restart > start > replay.
- restart: length <= 0, stay in IDLE.
- start with full=0: go to APPEND.
- start with full=1: no append; go to SHOW.
- replay with length>0: go to SHOW.
- replay with length=0: ignored.
REQ-021 APPEND SHALL write new_code (as sampled with start) to mem[length], increment length, set idx=0, and go to SHOW.
- With a start sampled at edge N, prompt SHALL be nonzero from edge N+2.
REQ-022 SHOW SHALL drive prompt = mem[idx]+1 for exactly ON_TICKS cycles, then go to GAP.
REQ-023 GAP SHALL drive prompt = 0 for exactly GAP_TICKS cycles.
- Then, if idx == length-1: go to LISTEN with idx=0.
- Otherwise: idx++ and return to SHOW.
REQ-024 In LISTEN, on user_valid:
- user_code == mem[idx] and idx == length-1: go to PASS.
- user_code == mem[idx] and idx < length-1: idx++.
- user_code != mem[idx]: go to FAIL.
REQ-025 PASS SHALL assert round_pass for one cycle and FAIL SHALL assert round_fail for one cycle; both SHALL return to IDLE on the next edge; length SHALL be unchanged.
REQ-026 user_valid SHALL be ignored outside LISTEN, and start and replay SHALL be ignored outside IDLE.
REQ-027 restart in any non-IDLE state SHALL abort to IDLE on the next edge with length=0 and prompt=0, and SHALL NOT produce a pass or fail pulse.
REQ-028 round_pass and round_fail SHALL never be high together.
REQ-029 The tick counters SHALL be wide enough for the largest tick parameter, and idx SHALL never exceed length-1.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force: state=IDLE, length=0, idx=0, all counters=0, prompt=0, busy=0, round_pass=0, round_fail=0, full=0.
REQ-031 Sequence memory contents SHALL NOT be reset; they are don't-care when length=0.
REQ-032 Reset asserted mid-round SHALL behave as REQ-030, and SHALL NOT produce a pass or fail pulse.

Configuration
REQ-033 With macro PROMPT_SEQUENCER_INPUT_TIMEOUT_EN defined, LISTEN SHALL go to FAIL after TIMEOUT_TICKS consecutive cycles without user_valid; the count SHALL restart on LISTEN entry and on each accepted input.
REQ-034 Without the macro, LISTEN SHALL wait indefinitely, and no timeout counter SHALL be synthesised.

Verification (DEPTH=4, ON_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=10)
REQ-035 After reset, start with new_code=2 -> prompt=3 for 4 cycles, then 0 for 2 cycles, then LISTEN; user_code=2 -> round_pass for 1 cycle, length=1, busy=0.
REQ-036 Rounds appending 0, 3, 1 -> third playback shows 1,4,2; user enters 0,3,2 -> round_fail on the edge after the third input, length=3.
REQ-037 replay after that failure -> playback 1,4,2 with no append, length still 3.
REQ-038 Fill to length 4 (full=1), then start -> no append, length=4, playback of all 4 codes.
REQ-039 restart asserted during SHOW -> next cycle prompt=0, busy=0, length=0, no pulse; a later user_valid is ignored.
REQ-040 Macro defined: no input for 10 cycles in LISTEN -> round_fail; macro undefined: the same stimulus leaves the block in LISTEN with busy=1.
